// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: the instruction memory read port and the decode issue
// handshake, including the decoder redirect controls fed back for next_pc.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc;
   logic        instr_valid;
   logic        id_ready;
   logic        branch_eq;
   logic        branch_ne;
   logic        jump;
   logic        zero;
   logic [31:0] retired;

   modport master (
      output imem_req, imem_addr, instr, opcode, pc, instr_valid, retired,
      input  imem_ack, imem_rdata, id_ready, branch_eq, branch_ne, jump, zero
   );

   modport slave (
      input  imem_req, imem_addr, instr, opcode, pc, instr_valid, retired,
      output imem_ack, imem_rdata, id_ready, branch_eq, branch_ne, jump, zero
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests the word at pc, holds it for decode, and
// advances pc (sequential, branch or jump) on each completed issue handshake.
//
// state | meaning
// IDLE  | post-reset bubble; moves to FETCH on the next edge
// FETCH | imem_req high at pc; waits (no timeout) for imem_ack
// ISSUE | instr held with instr_valid high until id_ready
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic              clk,
   input logic              rst,
   instr_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] retired_q;

   logic        req;
   logic        valid;
   logic        load_instr;
   logic        handshake;

   logic [31:0] pc4;
   logic [31:0] branch_off;
   logic [31:0] jump_target;
   logic        taken;
   logic [31:0] next_pc;

   // State register; reset lands in IDLE immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-state outputs. imem_ack only matters in FETCH and
   // id_ready only in ISSUE, so stray pulses elsewhere fall through.
   always_comb begin
      state_nxt  = state;
      req        = 1'b0;
      valid      = 1'b0;
      load_instr = 1'b0;
      handshake  = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            req = 1'b1;
            if (bus.imem_ack) begin
               load_instr = 1'b1;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            valid = 1'b1;
            if (bus.id_ready) begin
               handshake = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Redirect target for the held instruction. Jump beats any branch; with
   // both branch flavours set, taken is simply the OR of the two conditions.
   always_comb begin
      pc4         = pc_q + 32'd4;
      branch_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      jump_target = {pc4[31:28], instr_q[25:0], 2'b00};
      taken       = (bus.branch_eq & bus.zero) | (bus.branch_ne & ~bus.zero);
      next_pc     = pc4;
      if (bus.jump) begin
         next_pc = jump_target;
      end else if (taken) begin
         next_pc = pc4 + branch_off;
      end
   end

   // Datapath: capture the fetched word, then advance pc and the retire count
   // on the issue handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         instr_q   <= 32'd0;
         retired_q <= 32'd0;
      end else begin
         if (load_instr) begin
            instr_q <= bus.imem_rdata;
         end
         if (handshake) begin
            pc_q      <= next_pc;
            retired_q <= retired_q + 32'd1;
         end
      end
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.opcode      = instr_q[31:26];
   assign bus.pc          = pc_q;
   assign bus.instr_valid = valid;
   assign bus.retired     = retired_q;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The parameter list SHALL be: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high. Ports are clk and rst.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: imem_req  output  1  instruction memory read request.
REQ-006 Port: imem_addr  output  32  byte address of the requested instruction; equals pc.
REQ-007 Port: imem_ack  input  1  memory read data valid; sampled only in FETCH.
REQ-008 Port: imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-009 Port: instr  output  32  held instruction word presented to decode.
REQ-010 Port: opcode  output  6  instr[31:26], driving the decoder opcode input.
REQ-011 Port: pc  output  32  address of the held or requested instruction.
REQ-012 Port: instr_valid  output  1  instr/opcode valid for decode.
REQ-013 Port: id_ready  input  1  decode accepts instr; completes the issue handshake.
REQ-014 Port: branch_eq, branch_ne, jump  input  1 each  decoder control outputs for the issued instr.
REQ-015 Port: zero  input  1  ALU equality flag for the issued instr.
REQ-016 Port: retired  output  32  count of completed issue handshakes.

Function
REQ-017 The FSM SHALL have three states: IDLE, FETCH and ISSUE. Reset SHALL force IDLE.
- IDLE -> FETCH on the next edge, unconditionally.
REQ-018 In FETCH: imem_req=1, imem_addr=pc held stable, instr_valid=0.
- At an edge with imem_ack=1: instr <= imem_rdata, state -> ISSUE.
- Otherwise the block stays in FETCH with no timeout.
REQ-019 In ISSUE: imem_req=0 and instr_valid=1; instr/opcode/pc SHALL be held stable until handshake.
REQ-020 Handshake: an edge in ISSUE with id_ready=1 SHALL perform all of:
- pc <= next_pc;
- retired <= retired+1, wrapping modulo 2^32;
- state -> FETCH.
REQ-021 With id_ready=0 in ISSUE, the block SHALL keep the state and ignore the redirect inputs.
REQ-022 next_pc SHALL be computed combinationally from instr, pc and the redirect inputs sampled in the handshake cycle, with pc4 = pc+4 (32-bit, wraps):
- If jump=1: {pc4[31:28], instr[25:0], 2'b00}.
- Else if taken = (branch_eq & zero) | (branch_ne & ~zero): pc4 + (sign_extend(instr[15:0]) << 2), 32-bit wrap.
- Else: pc4.
REQ-023 jump SHALL have priority over branches. branch_eq=branch_ne=1 SHALL evaluate taken as the OR above.
REQ-024 imem_ack outside FETCH SHALL be ignored. imem_rdata outside an acked FETCH edge SHALL be ignored.
REQ-025 Best-case throughput SHALL be one instruction per 2 cycles: ack on the first FETCH cycle, id_ready on the first ISSUE cycle.
REQ-026 pc[1:0] SHALL always be 2'b00 when RESET_PC is word aligned. No alignment checking is performed.

Reset
REQ-027 Asserting rst SHALL immediately set all of the following, regardless of state, including mid-FETCH with a request outstanding:
- state=IDLE;
- pc=RESET_PC;
- instr=0, so opcode=0;
- instr_valid=0, imem_req=0;
- retired=0.
REQ-028 After rst deasserts, imem_req SHALL rise one edge later, with imem_addr=RESET_PC.

Verification
REQ-029 Reset then ack the first FETCH cycle with rdata 0x0000_0020 and hold id_ready=1 -> pc sequence 0x0, 0x4, 0x8 every 2 cycles; retired=3 after 3 handshakes.
REQ-030 At pc 0x8, instr 0x1000_0003, branch_eq=1, zero=1 -> next pc 0x18. Repeat with zero=0 -> 0xC.
REQ-031 At pc 0x4, instr 0x0800_0010, jump=1 with branch_eq=1 and zero=1 also asserted -> next pc 0x40 (jump priority).
REQ-032 At pc 0x10, instr 0x1400_FFFF, branch_ne=1, zero=0 -> next pc 0x10. At pc 0xFFFF_FFFC with no redirect -> pc 0x0.
REQ-033 Hold imem_ack=0 for 5 cycles -> imem_req stays 1 and imem_addr is stable. Pulse imem_ack while in ISSUE -> instr unchanged.
REQ-034 Assert rst mid-FETCH and mid-ISSUE with id_ready=0 -> outputs reach reset values without a clock edge, and fetch restarts at RESET_PC.
